hazard_scoreboard: RTL and testbench
====================================

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameter REG_AW, default 5: register-address width.
REQ-002 Parameter MDU_LAT, default 4: multiply/divide latency in cycles, legal range 2..15.
REQ-003 Parameter STAT_W, default 16: stall-statistics counter width.
REQ-004 clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 rs_d, rt_d, rs_e, rt_e  in  REG_AW  source registers in D and E.
REQ-007 write_reg_e, write_reg_m, write_reg_w  in  REG_AW  destination registers in E, M and W.
REQ-008 sig_reg_write_e/m/w  in  1  destination is written in E/M/W.
REQ-009 sig_mem_to_reg_e/m  in  1  load in E/M.
REQ-010 sig_branch_d, sig_jr_d, sig_syscall_d, sig_jal_d, sig_mdu_read_d  in  1  D-stage instruction class (sig_mdu_read_d = mfhi/mflo).
REQ-011 sig_mdu_start_e  in  1  mult/div issuing from E this cycle.
REQ-012 stall_f, stall_d, flush_e  out  1  pipeline control.
REQ-013 forward_a_d, forward_b_d  out  1  D-stage comparator operand bypass from M.
REQ-014 forward_a_e, forward_b_e  out  2  E-stage ALU operand select: 10 = M, 01 = W, 00 = register file.
REQ-015 mdu_busy  out  1  multiply/divide result pending.
REQ-016 stall_cycles  out  STAT_W  saturating count of cycles with stall_d high.

Function
REQ-017 Forwarding into E is combinational: forward_a_e = 10 when rs_e!=0, rs_e==write_reg_m and sig_reg_write_m; else 01 when the same holds against W; else 00. forward_b_e uses rt_e identically. M has priority over W.
REQ-018 forward_a_d = rs_d!=0 && rs_d==write_reg_m && sig_reg_write_m; forward_b_d uses rt_d identically.
REQ-019 lwstall = sig_mem_to_reg_e && write_reg_e!=0 && (write_reg_e==rs_d || write_reg_e==rt_d).
REQ-020 brstall = (sig_branch_d||sig_jr_d) && ((sig_reg_write_e && write_reg_e!=0 && write_reg_e matches rs_d or rt_d) || (sig_mem_to_reg_m && write_reg_m!=0 && write_reg_m matches rs_d or rt_d)).
REQ-021 MDU counter: sig_mdu_start_e loads MDU_LAT-1; otherwise the counter decrements by 1 per cycle while nonzero, including stalled cycles. A start while nonzero reloads MDU_LAT-1. mdu_busy = (counter!=0).
REQ-022 mdustall = sig_mdu_read_d && (mdu_busy || sig_mdu_start_e).
REQ-023 syspend = any of E/M/W has sig_reg_write_x set with write_reg_x equal to 2 (v0) or 4 (a0), or mdu_busy is high.
REQ-024 FSM states: IDLE, SYS_WAIT, JAL_HOLD.
- IDLE: sig_syscall_d && syspend -> SYS_WAIT.
- IDLE: otherwise, sig_jal_d with no other stall term true -> JAL_HOLD.
- SYS_WAIT: stays while syspend; otherwise -> IDLE.
- JAL_HOLD: -> IDLE unconditionally.
REQ-025 sysstall = sig_syscall_d && syspend, evaluated in IDLE and SYS_WAIT. jalstall = sig_jal_d && state==IDLE && no other stall term true.
REQ-026 stall_f = stall_d = flush_e = lwstall | brstall | mdustall | sysstall | jalstall.
REQ-027 A JAL stalls exactly one cycle. While in JAL_HOLD the same JAL in D does not re-stall.
REQ-028 stall_cycles increments on every cycle stall_d is high and holds at all-ones.
REQ-029 Simultaneous stall terms OR together. The FSM transition priority is syscall over JAL.

Reset
REQ-030 Asserting rst immediately forces the FSM to IDLE, the MDU counter to 0 and stall_cycles to 0, mid-operation included. While rst is high, mdu_busy = 0 and stalls are computed with state IDLE.
REQ-031 Forward outputs are purely combinational and unaffected by rst.

Structure
REQ-032 The register numbers v0=2 and a0=4, the forward-select encodings and the FSM state encodings are defined in the shared ManBearPig.h header.
REQ-033 The MDU countdown is a sub-module, mdu_busy_counter (ports: clk, rst, start, busy), parametrised by MDU_LAT.

Verification
REQ-034 write_reg_m=8 with sig_reg_write_m=1, write_reg_w=8 with sig_reg_write_w=1, rs_e=8 -> forward_a_e=10. Repeat with rs_e=0 -> 00.
REQ-035 Load to $9 in E, rt_d=9 -> stall_f/stall_d/flush_e=1 for one cycle; the same load to $0 -> no stall.
REQ-036 sig_mdu_start_e pulse with MDU_LAT=4 -> mdu_busy high for 3 cycles. mfhi in D over that window -> stall on each of those cycles plus the start cycle, released on the 5th.
REQ-037 Syscall in D while an E-stage write to $2 drains through M and W -> FSM in SYS_WAIT, stall for 3 cycles, IDLE and release when W clears.
REQ-038 jal held in D -> exactly one stall+flush cycle, then JAL_HOLD, then IDLE. rst asserted during SYS_WAIT -> IDLE, stall_cycles=0 and mdu_busy=0 immediately.

Source files
------------

// File: rtl/hazard_scoreboard_pkg.sv
`default_nettype none
// ============================================================================
// Module  : hazard_scoreboard_pkg
// Brief   : Shared constants for the hazard scoreboard: special register
//           numbers, forward-select encodings and FSM state encodings.
// Revision: 1.0  initial release
// ============================================================================
package hazard_scoreboard_pkg;

  // Registers that a syscall reads implicitly (service number and argument)
  localparam int unsigned REG_V0 = 2;
  localparam int unsigned REG_A0 = 4;

  // E-stage ALU operand select encodings
  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  // Hazard FSM state encodings
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE     = 2'd0;
  localparam state_t ST_SYS_WAIT = 2'd1;
  localparam state_t ST_JAL_HOLD = 2'd2;

endpackage
`default_nettype wire

// File: rtl/hazard_scoreboard_mdu_busy_counter.sv
`default_nettype none
// ============================================================================
// Module  : mdu_busy_counter
// Brief   : Countdown tracking an in-flight multiply/divide. A start loads
//           MDU_LAT-1 (also when already counting); the count then falls by
//           one per cycle until zero. busy is high while the count is nonzero.
// Revision: 1.0  initial release
// ============================================================================
module mdu_busy_counter #(
  parameter int MDU_LAT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic busy
);

  // Four bits cover the whole legal latency range (2..15)
  localparam logic [3:0] LOAD_VAL = 4'(MDU_LAT - 1);

  logic [3:0] count;

  // Load on start, otherwise drain toward zero; stalls do not pause it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 4'd0;
    end else if (start) begin
      count <= LOAD_VAL;
    end else if (count != 4'd0) begin
      count <= count - 4'd1;
    end
  end

  assign busy = (count != 4'd0);

endmodule
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module  : hazard_scoreboard
// Brief   : Hazard detection and forwarding control for a 5-stage pipeline:
//           E/D-stage bypass selects, load-use, branch, MDU-read, syscall and
//           JAL stalls, plus a saturating stall-cycle statistic.
// Revision: 1.0  initial release
// ============================================================================
module hazard_scoreboard #(
  parameter int REG_AW  = 5,
  parameter int MDU_LAT = 4,
  parameter int STAT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] rs_d,
  input  logic [REG_AW-1:0] rt_d,
  input  logic [REG_AW-1:0] rs_e,
  input  logic [REG_AW-1:0] rt_e,
  input  logic [REG_AW-1:0] write_reg_e,
  input  logic [REG_AW-1:0] write_reg_m,
  input  logic [REG_AW-1:0] write_reg_w,
  input  logic              sig_reg_write_e,
  input  logic              sig_reg_write_m,
  input  logic              sig_reg_write_w,
  input  logic              sig_mem_to_reg_e,
  input  logic              sig_mem_to_reg_m,
  input  logic              sig_branch_d,
  input  logic              sig_jr_d,
  input  logic              sig_syscall_d,
  input  logic              sig_jal_d,
  input  logic              sig_mdu_read_d,
  input  logic              sig_mdu_start_e,
  output logic              stall_f,
  output logic              stall_d,
  output logic              flush_e,
  output logic              forward_a_d,
  output logic              forward_b_d,
  output logic [1:0]        forward_a_e,
  output logic [1:0]        forward_b_e,
  output logic              mdu_busy,
  output logic [STAT_W-1:0] stall_cycles
);

  import hazard_scoreboard_pkg::*;

  localparam logic [REG_AW-1:0] ZERO_REG = '0;
  localparam logic [REG_AW-1:0] V0_REG   = REG_AW'(REG_V0);
  localparam logic [REG_AW-1:0] A0_REG   = REG_AW'(REG_A0);
  localparam logic [STAT_W-1:0] STAT_MAX = '1;

  state_t state;
  state_t state_next;

  logic lwstall;
  logic brstall;
  logic mdustall;
  logic sysstall;
  logic jalstall;
  logic other_stall;
  logic syspend;
  logic stall_any;
  logic e_hits_d;
  logic m_hits_d;

  // ---------------------------------------------------------------------------
  // Forwarding (purely combinational, independent of reset)
  // ---------------------------------------------------------------------------

  // E-stage operand selects: M result wins over W result
  always_comb begin
    forward_a_e = FWD_RF;
    if (rs_e != ZERO_REG && rs_e == write_reg_m && sig_reg_write_m)
      forward_a_e = FWD_M;
    else if (rs_e != ZERO_REG && rs_e == write_reg_w && sig_reg_write_w)
      forward_a_e = FWD_W;

    forward_b_e = FWD_RF;
    if (rt_e != ZERO_REG && rt_e == write_reg_m && sig_reg_write_m)
      forward_b_e = FWD_M;
    else if (rt_e != ZERO_REG && rt_e == write_reg_w && sig_reg_write_w)
      forward_b_e = FWD_W;
  end

  assign forward_a_d = (rs_d != ZERO_REG) && (rs_d == write_reg_m) && sig_reg_write_m;
  assign forward_b_d = (rt_d != ZERO_REG) && (rt_d == write_reg_m) && sig_reg_write_m;

  // ---------------------------------------------------------------------------
  // MDU busy tracking
  // ---------------------------------------------------------------------------
  mdu_busy_counter #(
    .MDU_LAT (MDU_LAT)
  ) u_mdu_busy_counter (
    .clk   (clk),
    .rst   (rst),
    .start (sig_mdu_start_e),
    .busy  (mdu_busy)
  );

  // ---------------------------------------------------------------------------
  // Stall terms
  // ---------------------------------------------------------------------------
  assign e_hits_d = (write_reg_e != ZERO_REG) &&
                    ((write_reg_e == rs_d) || (write_reg_e == rt_d));
  assign m_hits_d = (write_reg_m != ZERO_REG) &&
                    ((write_reg_m == rs_d) || (write_reg_m == rt_d));

  assign lwstall  = sig_mem_to_reg_e && e_hits_d;

  // A branch compares in D, so an E-stage result or an M-stage load cannot
  // be bypassed in time
  assign brstall  = (sig_branch_d || sig_jr_d) &&
                    ((sig_reg_write_e && e_hits_d) || (sig_mem_to_reg_m && m_hits_d));

  // The start cycle itself counts as busy for an mfhi/mflo behind it
  assign mdustall = sig_mdu_read_d && (mdu_busy || sig_mdu_start_e);

  // Syscall must see settled v0/a0 and a quiet MDU
  assign syspend  = (sig_reg_write_e && (write_reg_e == V0_REG || write_reg_e == A0_REG)) ||
                    (sig_reg_write_m && (write_reg_m == V0_REG || write_reg_m == A0_REG)) ||
                    (sig_reg_write_w && (write_reg_w == V0_REG || write_reg_w == A0_REG)) ||
                    mdu_busy;

  assign sysstall    = sig_syscall_d && syspend &&
                       (state == ST_IDLE || state == ST_SYS_WAIT);
  assign other_stall = lwstall | brstall | mdustall | sysstall;

  // A JAL takes its single bubble only when nothing else is already stalling
  assign jalstall    = sig_jal_d && (state == ST_IDLE) && !other_stall;

  assign stall_any = other_stall | jalstall;
  assign stall_f   = stall_any;
  assign stall_d   = stall_any;
  assign flush_e   = stall_any;

  // ---------------------------------------------------------------------------
  // Hazard FSM
  // ---------------------------------------------------------------------------

  // Next-state selection; syscall takes priority over JAL out of IDLE
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (sig_syscall_d && syspend)
          state_next = ST_SYS_WAIT;
        else if (jalstall)
          state_next = ST_JAL_HOLD;
      end
      ST_SYS_WAIT: begin
        if (!syspend)
          state_next = ST_IDLE;
      end
      ST_JAL_HOLD: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State register, forced to IDLE the moment reset asserts
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= ST_IDLE;
    else
      state <= state_next;
  end

  // ---------------------------------------------------------------------------
  // Stall statistics
  // ---------------------------------------------------------------------------

  // Count stalled cycles, sticking at all-ones
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_cycles <= '0;
    else if (stall_d && stall_cycles != STAT_MAX)
      stall_cycles <= stall_cycles + STAT_W'(1);
  end

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module  : tb_hazard_scoreboard
// Brief   : Directed self-checking bench for hazard_scoreboard
//           (REG_AW=5, MDU_LAT=4, STAT_W=3 so saturation is reachable).
// Revision: 1.0  initial release
// ============================================================================
module tb_hazard_scoreboard;

  localparam int REG_AW  = 5;
  localparam int MDU_LAT = 4;
  localparam int STAT_W  = 3;

  logic              clk;
  logic              rst;
  logic [REG_AW-1:0] rs_d, rt_d, rs_e, rt_e;
  logic [REG_AW-1:0] write_reg_e, write_reg_m, write_reg_w;
  logic              sig_reg_write_e, sig_reg_write_m, sig_reg_write_w;
  logic              sig_mem_to_reg_e, sig_mem_to_reg_m;
  logic              sig_branch_d, sig_jr_d, sig_syscall_d, sig_jal_d, sig_mdu_read_d;
  logic              sig_mdu_start_e;
  logic              stall_f, stall_d, flush_e;
  logic              forward_a_d, forward_b_d;
  logic [1:0]        forward_a_e, forward_b_e;
  logic              mdu_busy;
  logic [STAT_W-1:0] stall_cycles;

  int total;
  int bad;

  hazard_scoreboard #(
    .REG_AW  (REG_AW),
    .MDU_LAT (MDU_LAT),
    .STAT_W  (STAT_W)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .rs_d             (rs_d),
    .rt_d             (rt_d),
    .rs_e             (rs_e),
    .rt_e             (rt_e),
    .write_reg_e      (write_reg_e),
    .write_reg_m      (write_reg_m),
    .write_reg_w      (write_reg_w),
    .sig_reg_write_e  (sig_reg_write_e),
    .sig_reg_write_m  (sig_reg_write_m),
    .sig_reg_write_w  (sig_reg_write_w),
    .sig_mem_to_reg_e (sig_mem_to_reg_e),
    .sig_mem_to_reg_m (sig_mem_to_reg_m),
    .sig_branch_d     (sig_branch_d),
    .sig_jr_d         (sig_jr_d),
    .sig_syscall_d    (sig_syscall_d),
    .sig_jal_d        (sig_jal_d),
    .sig_mdu_read_d   (sig_mdu_read_d),
    .sig_mdu_start_e  (sig_mdu_start_e),
    .stall_f          (stall_f),
    .stall_d          (stall_d),
    .flush_e          (flush_e),
    .forward_a_d      (forward_a_d),
    .forward_b_d      (forward_b_d),
    .forward_a_e      (forward_a_e),
    .forward_b_e      (forward_b_e),
    .mdu_busy         (mdu_busy),
    .stall_cycles     (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] wm;
    logic       rwm;
    logic [4:0] ww;
    logic       rww;
    logic [1:0] ea;
    logic [1:0] eb;
  } fe_vec_t;

  task automatic clear_inputs();
    rs_d = '0; rt_d = '0; rs_e = '0; rt_e = '0;
    write_reg_e = '0; write_reg_m = '0; write_reg_w = '0;
    sig_reg_write_e = 1'b0; sig_reg_write_m = 1'b0; sig_reg_write_w = 1'b0;
    sig_mem_to_reg_e = 1'b0; sig_mem_to_reg_m = 1'b0;
    sig_branch_d = 1'b0; sig_jr_d = 1'b0; sig_syscall_d = 1'b0;
    sig_jal_d = 1'b0; sig_mdu_read_d = 1'b0; sig_mdu_start_e = 1'b0;
  endtask

  // Advance one clock and settle 1 time unit past the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    #3;
    total++; if (stall_cycles !== 3'd0) begin bad++; $display("FAIL reset_stat got=%0d want=0", stall_cycles); end
    total++; if (mdu_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", mdu_busy); end
    total++; if ({stall_f, stall_d, flush_e} !== 3'b000) begin bad++; $display("FAIL reset_stall got=%b want=000", {stall_f, stall_d, flush_e}); end
    tick();
    rst = 1'b0;
    #1;
    total++; if ({forward_a_e, forward_b_e, forward_a_d, forward_b_d} !== 6'b0) begin bad++; $display("FAIL reset_fwd got=%b want=000000", {forward_a_e, forward_b_e, forward_a_d, forward_b_d}); end
  endtask

  task automatic test_forward_e();
    fe_vec_t v [6];
    v[0] = '{rs:5'd8, rt:5'd0, wm:5'd8, rwm:1'b1, ww:5'd8, rww:1'b1, ea:2'b10, eb:2'b00};
    v[1] = '{rs:5'd0, rt:5'd0, wm:5'd8, rwm:1'b1, ww:5'd8, rww:1'b1, ea:2'b00, eb:2'b00};
    v[2] = '{rs:5'd8, rt:5'd8, wm:5'd8, rwm:1'b0, ww:5'd8, rww:1'b1, ea:2'b01, eb:2'b01};
    v[3] = '{rs:5'd3, rt:5'd8, wm:5'd8, rwm:1'b1, ww:5'd3, rww:1'b1, ea:2'b01, eb:2'b10};
    v[4] = '{rs:5'd5, rt:5'd6, wm:5'd8, rwm:1'b1, ww:5'd7, rww:1'b1, ea:2'b00, eb:2'b00};
    v[5] = '{rs:5'd7, rt:5'd7, wm:5'd8, rwm:1'b1, ww:5'd7, rww:1'b0, ea:2'b00, eb:2'b00};
    clear_inputs();
    for (int i = 0; i < 6; i++) begin
      rs_e = v[i].rs; rt_e = v[i].rt;
      write_reg_m = v[i].wm; sig_reg_write_m = v[i].rwm;
      write_reg_w = v[i].ww; sig_reg_write_w = v[i].rww;
      #1;
      total++; if (forward_a_e !== v[i].ea) begin bad++; $display("FAIL fwd_a_e[%0d] got=%b want=%b", i, forward_a_e, v[i].ea); end
      total++; if (forward_b_e !== v[i].eb) begin bad++; $display("FAIL fwd_b_e[%0d] got=%b want=%b", i, forward_b_e, v[i].eb); end
    end
    clear_inputs();
    #1;
  endtask

  task automatic test_forward_d();
    clear_inputs();
    write_reg_m = 5'd7; sig_reg_write_m = 1'b1; rs_d = 5'd7; rt_d = 5'd7;
    #1;
    total++; if ({forward_a_d, forward_b_d} !== 2'b11) begin bad++; $display("FAIL fwd_d_both got=%b want=11", {forward_a_d, forward_b_d}); end
    rs_d = 5'd0; rt_d = 5'd7;
    #1;
    total++; if ({forward_a_d, forward_b_d} !== 2'b01) begin bad++; $display("FAIL fwd_d_zero got=%b want=01", {forward_a_d, forward_b_d}); end
    write_reg_w = 5'd7; sig_reg_write_w = 1'b1; sig_reg_write_m = 1'b0; rs_d = 5'd7;
    #1;
    total++; if ({forward_a_d, forward_b_d} !== 2'b00) begin bad++; $display("FAIL fwd_d_nowrite got=%b want=00", {forward_a_d, forward_b_d}); end
    clear_inputs();
    #1;
  endtask

  task automatic test_lwstall();
    do_reset();
    sig_mem_to_reg_e = 1'b1; sig_reg_write_e = 1'b1; write_reg_e = 5'd9; rt_d = 5'd9;
    #1;
    total++; if ({stall_f, stall_d, flush_e} !== 3'b111) begin bad++; $display("FAIL lw_stall got=%b want=111", {stall_f, stall_d, flush_e}); end
    tick();
    // Load advances to M; no branch in D so no further stall
    sig_mem_to_reg_e = 1'b0; sig_reg_write_e = 1'b0; write_reg_e = 5'd0;
    sig_mem_to_reg_m = 1'b1; sig_reg_write_m = 1'b1; write_reg_m = 5'd9;
    #1;
    total++; if (stall_d !== 1'b0) begin bad++; $display("FAIL lw_release got=%b want=0", stall_d); end
    total++; if (forward_b_d !== 1'b1) begin bad++; $display("FAIL lw_fwd_d got=%b want=1", forward_b_d); end
    total++; if (stall_cycles !== 3'd1) begin bad++; $display("FAIL lw_stat got=%0d want=1", stall_cycles); end
    clear_inputs();
    sig_mem_to_reg_e = 1'b1; sig_reg_write_e = 1'b1; write_reg_e = 5'd0; rt_d = 5'd0;
    #1;
    total++; if (stall_d !== 1'b0) begin bad++; $display("FAIL lw_zero got=%b want=0", stall_d); end
    clear_inputs();
    #1;
  endtask

  task automatic test_brstall();
    clear_inputs();
    sig_branch_d = 1'b1; rs_d = 5'd5; sig_reg_write_e = 1'b1; write_reg_e = 5'd5;
    #1;
    total++; if (stall_d !== 1'b1) begin bad++; $display("FAIL br_e got=%b want=1", stall_d); end
    clear_inputs();
    sig_jr_d = 1'b1; rt_d = 5'd6; sig_mem_to_reg_m = 1'b1; sig_reg_write_m = 1'b1; write_reg_m = 5'd6;
    #1;
    total++; if (stall_d !== 1'b1) begin bad++; $display("FAIL br_mload got=%b want=1", stall_d); end
    clear_inputs();
    sig_branch_d = 1'b1; rs_d = 5'd5; sig_reg_write_m = 1'b1; write_reg_m = 5'd5;
    #1;
    total++; if (stall_d !== 1'b0) begin bad++; $display("FAIL br_malu got=%b want=0", stall_d); end
    clear_inputs();
    sig_branch_d = 1'b1; sig_reg_write_e = 1'b1; write_reg_e = 5'd0;
    #1;
    total++; if (stall_d !== 1'b0) begin bad++; $display("FAIL br_zero got=%b want=0", stall_d); end
    clear_inputs();
    #1;
  endtask

  task automatic test_mdu();
    do_reset();
    sig_mdu_start_e = 1'b1; sig_mdu_read_d = 1'b1;
    #1;
    total++; if (stall_d !== 1'b1) begin bad++; $display("FAIL mdu_start_stall got=%b want=1", stall_d); end
    total++; if (mdu_busy !== 1'b0) begin bad++; $display("FAIL mdu_start_busy got=%b want=0", mdu_busy); end
    tick();
    sig_mdu_start_e = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      #1;
      total++; if ({mdu_busy, stall_d} !== 2'b11) begin bad++; $display("FAIL mdu_busy_c%0d got=%b want=11", c, {mdu_busy, stall_d}); end
      tick();
    end
    total++; if ({mdu_busy, stall_d} !== 2'b00) begin bad++; $display("FAIL mdu_release got=%b want=00", {mdu_busy, stall_d}); end
    // Restart while counting reloads the full latency
    sig_mdu_read_d = 1'b0;
    sig_mdu_start_e = 1'b1; tick();
    sig_mdu_start_e = 1'b0; tick();
    sig_mdu_start_e = 1'b1; tick();
    sig_mdu_start_e = 1'b0;
    tick(); tick();
    total++; if (mdu_busy !== 1'b1) begin bad++; $display("FAIL mdu_reload_busy got=%b want=1", mdu_busy); end
    tick();
    total++; if (mdu_busy !== 1'b0) begin bad++; $display("FAIL mdu_reload_done got=%b want=0", mdu_busy); end
    clear_inputs();
    #1;
  endtask

  task automatic test_syscall();
    do_reset();
    // a0 write in E with syscall: stalls; withdrawn before the edge
    sig_syscall_d = 1'b1; sig_reg_write_e = 1'b1; write_reg_e = 5'd4;
    #1;
    total++; if (stall_d !== 1'b1) begin bad++; $display("FAIL sys_a0 got=%b want=1", stall_d); end
    clear_inputs();
    // v0 write drains E -> M -> W under the syscall
    sig_syscall_d = 1'b1; sig_reg_write_e = 1'b1; write_reg_e = 5'd2;
    #1;
    total++; if (stall_d !== 1'b1) begin bad++; $display("FAIL sys_e got=%b want=1", stall_d); end
    tick();
    sig_reg_write_e = 1'b0; write_reg_e = 5'd0; sig_reg_write_m = 1'b1; write_reg_m = 5'd2;
    #1;
    total++; if (stall_d !== 1'b1) begin bad++; $display("FAIL sys_m got=%b want=1", stall_d); end
    tick();
    sig_reg_write_m = 1'b0; write_reg_m = 5'd0; sig_reg_write_w = 1'b1; write_reg_w = 5'd2;
    #1;
    total++; if (stall_d !== 1'b1) begin bad++; $display("FAIL sys_w got=%b want=1", stall_d); end
    tick();
    // W clear: released; still in SYS_WAIT so a JAL here must not stall
    sig_reg_write_w = 1'b0; write_reg_w = 5'd0; sig_syscall_d = 1'b0; sig_jal_d = 1'b1;
    #1;
    total++; if (stall_d !== 1'b0) begin bad++; $display("FAIL sys_release got=%b want=0", stall_d); end
    tick();
    // Back in IDLE: the JAL now stalls
    total++; if (stall_d !== 1'b1) begin bad++; $display("FAIL sys_idle_jal got=%b want=1", stall_d); end
    total++; if (stall_cycles !== 3'd3) begin bad++; $display("FAIL sys_stat got=%0d want=3", stall_cycles); end
    tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_jal();
    do_reset();
    sig_jal_d = 1'b1;
    #1;
    total++; if ({stall_f, stall_d, flush_e} !== 3'b111) begin bad++; $display("FAIL jal_first got=%b want=111", {stall_f, stall_d, flush_e}); end
    tick();
    total++; if (stall_d !== 1'b0) begin bad++; $display("FAIL jal_hold got=%b want=0", stall_d); end
    sig_jal_d = 1'b0;
    tick();
    total++; if (stall_d !== 1'b0) begin bad++; $display("FAIL jal_after got=%b want=0", stall_d); end
    // JAL behind a load-use stall: no JAL_HOLD entry, so it stalls again later
    sig_jal_d = 1'b1; sig_mem_to_reg_e = 1'b1; sig_reg_write_e = 1'b1; write_reg_e = 5'd3; rs_d = 5'd3;
    #1;
    total++; if (stall_d !== 1'b1) begin bad++; $display("FAIL jal_lw got=%b want=1", stall_d); end
    tick();
    sig_mem_to_reg_e = 1'b0; sig_reg_write_e = 1'b0; write_reg_e = 5'd0; rs_d = 5'd0;
    #1;
    total++; if (stall_d !== 1'b1) begin bad++; $display("FAIL jal_after_lw got=%b want=1", stall_d); end
    tick();
    total++; if (stall_d !== 1'b0) begin bad++; $display("FAIL jal_after_lw_hold got=%b want=0", stall_d); end
    clear_inputs();
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    sig_syscall_d = 1'b1; sig_reg_write_w = 1'b1; write_reg_w = 5'd4; sig_mdu_start_e = 1'b1;
    tick();
    sig_mdu_start_e = 1'b0;
    #1;
    total++; if ({stall_cycles, mdu_busy} !== {3'd1, 1'b1}) begin bad++; $display("FAIL rstmid_pre got=%0d/%b want=1/1", stall_cycles, mdu_busy); end
    // Asynchronous reset in the middle of the cycle, in SYS_WAIT
    rst = 1'b1;
    sig_syscall_d = 1'b0; sig_reg_write_w = 1'b0; write_reg_w = 5'd0; sig_jal_d = 1'b1;
    rs_e = 5'd8; write_reg_m = 5'd8; sig_reg_write_m = 1'b1;
    #1;
    total++; if (stall_cycles !== 3'd0) begin bad++; $display("FAIL rstmid_stat got=%0d want=0", stall_cycles); end
    total++; if (mdu_busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b want=0", mdu_busy); end
    total++; if (stall_d !== 1'b1) begin bad++; $display("FAIL rstmid_idle_jal got=%b want=1", stall_d); end
    total++; if (forward_a_e !== 2'b10) begin bad++; $display("FAIL rstmid_fwd got=%b want=10", forward_a_e); end
    tick();
    total++; if (stall_cycles !== 3'd0) begin bad++; $display("FAIL rstmid_hold got=%0d want=0", stall_cycles); end
    rst = 1'b0;
    clear_inputs();
    tick();
  endtask

  task automatic test_stat_sat();
    do_reset();
    sig_mem_to_reg_e = 1'b1; write_reg_e = 5'd11; rs_d = 5'd11;
    for (int c = 0; c < 5; c++) tick();
    total++; if (stall_cycles !== 3'd5) begin bad++; $display("FAIL stat_five got=%0d want=5", stall_cycles); end
    for (int c = 0; c < 4; c++) tick();
    total++; if (stall_cycles !== 3'd7) begin bad++; $display("FAIL stat_sat got=%0d want=7", stall_cycles); end
    clear_inputs();
    tick();
    total++; if (stall_cycles !== 3'd7) begin bad++; $display("FAIL stat_hold got=%0d want=7", stall_cycles); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    clear_inputs();
    test_reset();
    test_forward_e();
    test_forward_d();
    test_lwstall();
    test_brstall();
    test_mdu();
    test_syscall();
    test_jal();
    test_reset_mid();
    test_stat_sat();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
